dmem_access_ctrl: RTL
=====================

# dmem_access_ctrl

Memory-stage controller that sequences data-memory loads and stores over a variable-latency request/grant/response bus. It sits beside the M stage, ahead of the memory-to-writeback pipeline register. It stalls the front of the pipeline (F/D/E/M) while an access is outstanding and injects bubbles into the writeback stage. It also performs byte-lane steering for stores and sign/zero extension for loads (RV64I widths).

## Interface
- No parameters; datapath is fixed at 64 bits, addresses 64 bits.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- MemRead_M  in  1  M-stage instruction is a load.
- MemWrite_M  in  1  M-stage instruction is a store; never both set.
- Funct3_M  in  3  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- ALUResult_M  in  64  effective byte address.
- WriteData_M  in  64  store data, right-aligned.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = store.
- mem_addr  out  64  doubleword address {addr[63:3],3'b000}.
- mem_wdata  out  64  store data replicated into the addressed lanes.
- mem_wstrb  out  8  byte-lane write enables (0 for loads).
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  64  aligned doubleword read data.
- ReadData_M  out  64  extended load result, valid in DONE.
- Stall_M  out  1  hold PC, FD, DE, EM registers.
- BubbleW  out  1  MW register must load a bubble (RegWrite_W=0).
- MisalignErr_M  out  1  misaligned access detected.

## Operation
- access = MemRead_M | MemWrite_M. aligned = address low bits zero for the size: H needs [0]=0, W needs [1:0]=0, D needs [2:0]=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no access: all outputs idle, Stall_M=0.
- IDLE, access & !aligned: MisalignErr_M=1, BubbleW=1, Stall_M=0, no request; stay in IDLE.
- IDLE, access & aligned:
  - mem_req=1 combinationally, Stall_M=1; address, data, strobe, size and we are latched.
  - If mem_gnt: store goes to DONE, load goes to WAIT. Otherwise go to REQ.
- REQ: mem_req=1, driven from the latched values; Stall_M=1. On mem_gnt: store goes to DONE, load goes to WAIT.
- WAIT: Stall_M=1, mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE.
- DONE: Stall_M=0, BubbleW=0, mem_req=0; ReadData_M is driven. Next state is IDLE. The instruction advances into MW on this edge.
- BubbleW = Stall_M | MisalignErr_M.
- Lane steering uses addr[2:0]:
  - B: wstrb = 1 << a, wdata = {8{byte}}.
  - H: wstrb = 3 << a, wdata = {4{half}}.
  - W: wstrb = 0x0F << a, wdata = {2{word}}.
  - D: wstrb = 0xFF, wdata unchanged.
- Load extract: shift the captured doubleword right by 8*addr[2:0], then truncate to size. Sign-extend for B/H/W, zero-extend for BU/HU/WU; D passes through.
- Unsupported funct3 (111) is treated as D.
- Ignored inputs:
  - mem_rvalid in IDLE, REQ or DONE.
  - mem_gnt while mem_req=0.
- Reset (any time): state goes to IDLE and captured data is cleared. A response to a request in flight before reset is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ReadData_M=0, Stall_M=0, BubbleW=0, MisalignErr_M=0. State is IDLE.
- Non-memory instruction: 0 stall cycles.
- Store with immediate grant: 1 stall cycle (IDLE, then DONE).
- Load with immediate grant and rvalid the following cycle: 2 stall cycles (IDLE, WAIT, DONE).
- Each cycle of grant delay adds 1 REQ cycle; each cycle of response delay adds 1 WAIT cycle.
- mem_req, once raised, stays high with stable mem_addr, mem_we, mem_wdata and mem_wstrb until the cycle in which mem_gnt=1.
- At most one outstanding access.
- A new access is never issued in DONE, so back-to-back memory instructions are separated by the DONE cycle.
- Misaligned access: MisalignErr_M is high only for the cycle(s) the instruction sits in M, with no stall.

## Test plan
- Load, addr 0x1003, LB, gnt immediate, rvalid next cycle with rdata 0x0000_0000_8000_0000 (byte 3 = 0x80) -> Stall_M high 2 cycles, ReadData_M = 0xFFFF_FFFF_FFFF_FF80 in DONE, BubbleW high 2 cycles.
- Store SH, addr 0x2006, data 0xBEEF, gnt delayed 3 cycles -> mem_req high 4 cycles with stable mem_wstrb=0xC0 and mem_wdata=0xBEEF_BEEF_BEEF_BEEF, then DONE, Stall_M low.
- LWU, addr 0x10, rdata 0x0000_0000_F000_0001, rvalid 5 cycles after grant -> ReadData_M = 0x0000_0000_F000_0001, 6 stall cycles total.
- LW misaligned (addr 0x2) -> MisalignErr_M=1, BubbleW=1, mem_req stays 0, Stall_M=0.
- Two back-to-back LDs, both with immediate grant and next-cycle response -> second mem_req rises only in the cycle after the first DONE; no dropped or duplicated requests.
- rst asserted during WAIT, followed by a stray mem_rvalid -> all outputs zero, state IDLE, stray response ignored, next load completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the M stage: req/gnt/rvalid bus,
// store lane steering, load extraction, pipeline stall and bubble control.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  Funct3_M,
  input  logic [63:0] ALUResult_M,
  input  logic [63:0] WriteData_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [63:0] ReadData_M,
  output logic        Stall_M,
  output logic        BubbleW,
  output logic        MisalignErr_M
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        access, aligned;
  logic [1:0]  size;
  logic [7:0]  strb_c;
  logic [63:0] wdata_c;
  logic        latch, capture;

  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [63:0] shifted, ext;

  assign access = MemRead_M | MemWrite_M;
  assign size   = (Funct3_M == 3'b111) ? 2'd3 : Funct3_M[1:0];

  always_comb begin
    aligned = 1'b1;
    unique case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~ALUResult_M[0];
      2'd2:    aligned = (ALUResult_M[1:0] == 2'b00);
      default: aligned = (ALUResult_M[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    strb_c  = 8'hFF;
    wdata_c = WriteData_M;
    unique case (size)
      2'd0: begin
        strb_c  = 8'h01 << ALUResult_M[2:0];
        wdata_c = {8{WriteData_M[7:0]}};
      end
      2'd1: begin
        strb_c  = 8'h03 << ALUResult_M[2:0];
        wdata_c = {4{WriteData_M[15:0]}};
      end
      2'd2: begin
        strb_c  = 8'h0F << ALUResult_M[2:0];
        wdata_c = {2{WriteData_M[31:0]}};
      end
      default: begin
        strb_c  = 8'hFF;
        wdata_c = WriteData_M;
      end
    endcase
    if (!MemWrite_M) strb_c = 8'h00;
  end

  // Extraction works on the captured doubleword and the latched address.
  assign shifted = rdata_q >> {addr_q[2:0], 3'b000};

  always_comb begin
    ext = shifted;
    unique case (f3_q)
      3'b000:  ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {56'd0, shifted[7:0]};
      3'b101:  ext = {48'd0, shifted[15:0]};
      3'b110:  ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_n       = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 64'd0;
    mem_wdata     = 64'd0;
    mem_wstrb     = 8'h00;
    ReadData_M    = 64'd0;
    Stall_M       = 1'b0;
    MisalignErr_M = 1'b0;
    latch         = 1'b0;
    capture       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (access && !aligned) begin
            MisalignErr_M = 1'b1;
          end else if (access) begin
            latch     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = MemWrite_M;
            mem_addr  = {ALUResult_M[63:3], 3'b000};
            mem_wdata = wdata_c;
            mem_wstrb = strb_c;
            Stall_M   = 1'b1;
            if (mem_gnt) state_n = MemWrite_M ? DONE : WAIT;
            else         state_n = REQ;
          end
        end
        REQ: begin
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_addr  = {addr_q[63:3], 3'b000};
          mem_wdata = wdata_q;
          mem_wstrb = wstrb_q;
          Stall_M   = 1'b1;
          if (mem_gnt) state_n = we_q ? DONE : WAIT;
        end
        WAIT: begin
          Stall_M = 1'b1;
          if (mem_rvalid) begin
            capture = 1'b1;
            state_n = DONE;
          end
        end
        DONE: begin
          ReadData_M = we_q ? 64'd0 : ext;
          state_n    = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign BubbleW = Stall_M | MisalignErr_M;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'h00;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      rdata_q <= 64'd0;
    end else begin
      state <= state_n;
      if (latch) begin
        addr_q  <= ALUResult_M;
        wdata_q <= wdata_c;
        wstrb_q <= strb_c;
        we_q    <= MemWrite_M;
        f3_q    <= Funct3_M;
      end
      if (capture) rdata_q <= mem_rdata;
    end
  end

endmodule
